// File: rtl/ipv4_fwd_pkg.sv
// ipv4_fwd_pkg
// Shared definitions for the IPv4 forwarding sequencer:
//   - forwarding action codes carried in each decision record
//   - sequencer FSM state type
//   - decision record width helper ({action, port mask, next hop})
package ipv4_fwd_pkg;

    localparam logic [1:0] ACT_FWD  = 2'd0;
    localparam logic [1:0] ACT_CPU  = 2'd1;
    localparam logic [1:0] ACT_DROP = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RES,
        S_LOOKUP,
        S_PUSH
    } state_e;

    function automatic int unsigned dec_rec_width(input int unsigned num_ports);
        return 2 + num_ports + 32;
    endfunction

endpackage

// File: rtl/fwd_dec_fifo.sv
// fwd_dec_fifo
// Synchronous show-ahead FIFO holding forwarding decisions.
// Ports:
//   clk, resetn    clock, synchronous active-low reset (empties the FIFO)
//   push_i/data_i  write request and record
//   pop_i          read request (ignored while empty)
//   data_o         head record, forced to zero while empty
//   full_o/empty_o occupancy flags
//   count_o        number of stored records
module fwd_dec_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;

    // A pop frees the slot in the same cycle, so push-while-full is legal with a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ipv4_fwd_sched.sv
// ipv4_fwd_sched
// Per-packet sequencer for the IPv4 check stage of the output-port lookup.
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   i_tvalid/i_tready/i_tlast   snooped input stream handshake
//   i_is_ipv4                   ethertype is IPv4 (valid on beat 1)
//   o_pkt_word1/o_pkt_word2     beat 1 / beat 2 transferring (combinational)
//   o_hdr_ready                 0 stalls new packet starts (no decision slot)
//   i_can_handle..i_dst_ipv4    checker verdicts, sampled one cycle after word2
//   o_lpm_req/o_lpm_addr        LPM request (level) and key
//   i_lpm_ack/hit/nexthop/port  LPM response strobe and result
//   o_dec_*/i_dec_ready         decision FIFO read side
//   o_cnt_timeout               saturating count of lookup timeouts
module ipv4_fwd_sched
    import ipv4_fwd_pkg::*;
#(
    parameter int unsigned DEC_DEPTH   = 4,
    parameter int unsigned LPM_TIMEOUT = 64,
    parameter int unsigned NUM_PORTS   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_tvalid,
    input  logic                 i_tready,
    input  logic                 i_tlast,
    input  logic                 i_is_ipv4,
    output logic                 o_pkt_word1,
    output logic                 o_pkt_word2,
    output logic                 o_hdr_ready,
    input  logic                 i_can_handle,
    input  logic                 i_csum_ok,
    input  logic                 i_ttl_ok,
    input  logic [31:0]          i_dst_ipv4,
    output logic                 o_lpm_req,
    output logic [31:0]          o_lpm_addr,
    input  logic                 i_lpm_ack,
    input  logic                 i_lpm_hit,
    input  logic [31:0]          i_lpm_nexthop,
    input  logic [NUM_PORTS-1:0] i_lpm_port,
    output logic                 o_dec_valid,
    input  logic                 i_dec_ready,
    output logic [1:0]           o_dec_action,
    output logic [NUM_PORTS-1:0] o_dec_port,
    output logic [31:0]          o_dec_nexthop,
    output logic [15:0]          o_cnt_timeout
);

    localparam int unsigned DW = dec_rec_width(NUM_PORTS);
    localparam int unsigned CW = $clog2(DEC_DEPTH);

    state_e               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0]           act_q, act_d;
    logic [NUM_PORTS-1:0] port_q, port_d;
    logic [31:0]          nh_q, nh_d;
    logic [31:0]          dst_q, dst_d;
    logic [7:0]           timer_q, timer_d;
    logic [15:0]          tmo_q, tmo_d;

    logic                 beat;
    logic                 push;
    logic                 accept_start;
    logic                 load_dec;
    logic [1:0]           load_act;
    logic                 inflight;
    logic [CW:0]          fifo_cnt;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DW-1:0]        fifo_dout;

    assign beat        = i_tvalid & i_tready;
    assign o_pkt_word1 = beat & (cnt_q == 2'd0);
    assign o_pkt_word2 = beat & (cnt_q == 2'd1);

    always_comb begin
        cnt_d = cnt_q;
        if (beat) begin
            if (i_tlast)              cnt_d = 2'd0;
            else if (cnt_q != 2'd2)   cnt_d = cnt_q + 2'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        act_d        = act_q;
        port_d       = port_q;
        nh_d         = nh_q;
        dst_d        = dst_q;
        timer_d      = timer_q;
        tmo_d        = tmo_q;
        push         = 1'b0;
        accept_start = 1'b0;
        load_dec     = 1'b0;
        load_act     = ACT_CPU;

        unique case (state_q)
            S_IDLE: accept_start = 1'b1;
            S_HDR: begin
                if (o_pkt_word2) begin
                    state_d = S_RES;
                end else if (beat && i_tlast) begin
                    load_dec = 1'b1;
                    state_d  = S_PUSH;
                end
            end
            S_RES: begin
                if (!i_can_handle) begin
                    load_dec = 1'b1;
                    state_d  = S_PUSH;
                end else if (!i_csum_ok) begin
                    load_dec = 1'b1;
                    load_act = ACT_DROP;
                    state_d  = S_PUSH;
                end else if (!i_ttl_ok) begin
                    load_dec = 1'b1;
                    state_d  = S_PUSH;
                end else begin
                    dst_d   = i_dst_ipv4;
                    timer_d = '0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // Ack wins over a timer expiring in the same cycle.
                if (i_lpm_ack) begin
                    load_dec = 1'b1;
                    load_act = i_lpm_hit ? ACT_FWD : ACT_CPU;
                    state_d  = S_PUSH;
                end else if (timer_q == 8'(LPM_TIMEOUT - 1)) begin
                    load_dec = 1'b1;
                    if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
                    state_d  = S_PUSH;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_PUSH: begin
                push         = 1'b1;
                accept_start = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Packet start is handled identically in IDLE and PUSH; the record being
        // pushed this cycle is act_q/port_q/nh_q, so overwriting *_d is safe.
        if (accept_start && o_pkt_word1) begin
            if (!i_is_ipv4 || i_tlast) begin
                load_dec = 1'b1;
                state_d  = S_PUSH;
            end else begin
                state_d  = S_HDR;
            end
        end

        if (load_dec) begin
            act_d  = load_act;
            port_d = (load_act == ACT_FWD) ? i_lpm_port    : '0;
            nh_d   = (load_act == ACT_FWD) ? i_lpm_nexthop : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            act_q   <= ACT_FWD;
            port_q  <= '0;
            nh_q    <= '0;
            dst_q   <= '0;
            timer_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            port_q  <= port_d;
            nh_q    <= nh_d;
            dst_q   <= dst_d;
            timer_q <= timer_d;
            tmo_q   <= tmo_d;
        end
    end

    assign o_lpm_req     = (state_q == S_LOOKUP);
    assign o_lpm_addr    = o_lpm_req ? dst_q : '0;
    assign o_cnt_timeout = tmo_q;

    // Any packet past its first beat owns a FIFO slot until its PUSH retires.
    assign inflight    = (state_q != S_IDLE);
    assign o_hdr_ready = ~fifo_full &
                         ((32'(fifo_cnt) + (inflight ? 32'd1 : 32'd0)) < DEC_DEPTH);

    fwd_dec_fifo #(
        .WIDTH (DW),
        .DEPTH (DEC_DEPTH)
    ) u_dec_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .data_i  ({act_q, port_q, nh_q}),
        .pop_i   (i_dec_ready),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign o_dec_valid = ~fifo_empty;
    assign {o_dec_action, o_dec_port, o_dec_nexthop} = fifo_dout;

endmodule

// File: tb/tb_ipv4_fwd_sched.sv
// tb_ipv4_fwd_sched
// Scoreboard bench for ipv4_fwd_sched: expected decisions are queued when a
// packet is driven and compared when the DUT pops them from its decision FIFO.
module tb_ipv4_fwd_sched;

    localparam int unsigned DEC_DEPTH   = 4;
    localparam int unsigned LPM_TIMEOUT = 64;
    localparam int unsigned NUM_PORTS   = 8;

    localparam logic [1:0] E_FWD  = 2'd0;
    localparam logic [1:0] E_CPU  = 2'd1;
    localparam logic [1:0] E_DROP = 2'd2;

    typedef logic [41:0] dec_t;

    logic                 clk;
    logic                 resetn;
    logic                 i_tvalid, i_tready, i_tlast, i_is_ipv4;
    logic                 o_pkt_word1, o_pkt_word2, o_hdr_ready;
    logic                 i_can_handle, i_csum_ok, i_ttl_ok;
    logic [31:0]          i_dst_ipv4;
    logic                 o_lpm_req;
    logic [31:0]          o_lpm_addr;
    logic                 i_lpm_ack, i_lpm_hit;
    logic [31:0]          i_lpm_nexthop;
    logic [NUM_PORTS-1:0] i_lpm_port;
    logic                 o_dec_valid, i_dec_ready;
    logic [1:0]           o_dec_action;
    logic [NUM_PORTS-1:0] o_dec_port;
    logic [31:0]          o_dec_nexthop;
    logic [15:0]          o_cnt_timeout;

    ipv4_fwd_sched #(
        .DEC_DEPTH   (DEC_DEPTH),
        .LPM_TIMEOUT (LPM_TIMEOUT),
        .NUM_PORTS   (NUM_PORTS)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .i_tlast       (i_tlast),
        .i_is_ipv4     (i_is_ipv4),
        .o_pkt_word1   (o_pkt_word1),
        .o_pkt_word2   (o_pkt_word2),
        .o_hdr_ready   (o_hdr_ready),
        .i_can_handle  (i_can_handle),
        .i_csum_ok     (i_csum_ok),
        .i_ttl_ok      (i_ttl_ok),
        .i_dst_ipv4    (i_dst_ipv4),
        .o_lpm_req     (o_lpm_req),
        .o_lpm_addr    (o_lpm_addr),
        .i_lpm_ack     (i_lpm_ack),
        .i_lpm_hit     (i_lpm_hit),
        .i_lpm_nexthop (i_lpm_nexthop),
        .i_lpm_port    (i_lpm_port),
        .o_dec_valid   (o_dec_valid),
        .i_dec_ready   (i_dec_ready),
        .o_dec_action  (o_dec_action),
        .o_dec_port    (o_dec_port),
        .o_dec_nexthop (o_dec_nexthop),
        .o_cnt_timeout (o_cnt_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_assert = 0;
    int   n_fail   = 0;
    dec_t exp_q[$];

    task automatic assert_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // LPM responder configuration and observations
    int          lpm_delay = 1000;
    bit          lpm_hit   = 1'b0;
    logic [7:0]  lpm_port  = '0;
    logic [31:0] lpm_nh    = '0;
    int          lk_cyc    = 0;
    int          req_len   = 0;
    int          req_total = 0;
    bit          in_lk     = 1'b0;
    logic [31:0] addr_seen = '0;
    int          stray_req = 0;
    int          stray_done = 0;

    initial begin
        i_lpm_ack = 1'b0; i_lpm_hit = 1'b0; i_lpm_port = '0; i_lpm_nexthop = '0;
        forever begin
            @(negedge clk);
            i_lpm_hit     = lpm_hit;
            i_lpm_port    = lpm_port;
            i_lpm_nexthop = lpm_nh;
            if (!resetn) begin
                in_lk     = 1'b0;
                i_lpm_ack = 1'b0;
            end else if (o_lpm_req) begin
                if (!in_lk) begin
                    in_lk     = 1'b1;
                    lk_cyc    = 0;
                    addr_seen = o_lpm_addr;
                end
                req_total++;
                i_lpm_ack = (lk_cyc == lpm_delay);
                lk_cyc++;
            end else begin
                if (in_lk) begin
                    in_lk   = 1'b0;
                    req_len = lk_cyc;
                end
                i_lpm_ack  = (stray_req != stray_done);
                stray_done = stray_req;
            end
        end
    end

    // Decision monitor / scoreboard
    int word2_cyc = 0;
    int valid_rise_cyc = 0;
    bit prev_valid = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_valid = 1'b0;
            end else begin
                if (o_pkt_word2) word2_cyc = cyc;
                if (o_dec_valid && !prev_valid) valid_rise_cyc = cyc;
                prev_valid = o_dec_valid;
                if (o_dec_valid && i_dec_ready) begin
                    assert_eq("sb_pending", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0)
                        assert_eq("dec", 64'({o_dec_action, o_dec_port, o_dec_nexthop}),
                                  64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, got %0d cycles expected < 30000", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic dec_t model(input int nbeats, input bit ipv4, input bit can,
                                   input bit csum, input bit ttl);
        if (nbeats == 1 || !ipv4)                      return {E_CPU, 8'h00, 32'h0};
        if (!can)                                      return {E_CPU, 8'h00, 32'h0};
        if (!csum)                                     return {E_DROP, 8'h00, 32'h0};
        if (!ttl)                                      return {E_CPU, 8'h00, 32'h0};
        if (lpm_delay >= int'(LPM_TIMEOUT) || !lpm_hit) return {E_CPU, 8'h00, 32'h0};
        return {E_FWD, lpm_port, lpm_nh};
    endfunction

    task automatic send_pkt(input int nbeats, input bit ipv4, input bit can, input bit csum,
                            input bit ttl, input logic [31:0] dst, input bit record);
        if (record) exp_q.push_back(model(nbeats, ipv4, can, csum, ttl));
        i_can_handle = can;
        i_csum_ok    = csum;
        i_ttl_ok     = ttl;
        i_dst_ipv4   = dst;
        for (int b = 0; b < nbeats; b++) begin
            @(posedge clk); #1;
            i_tvalid  = 1'b1;
            i_tready  = 1'b1;
            i_tlast   = (b == nbeats - 1);
            i_is_ipv4 = (b == 0) ? ipv4 : 1'b0;
        end
        @(posedge clk); #1;
        i_tvalid  = 1'b0;
        i_tready  = 1'b0;
        i_tlast   = 1'b0;
        i_is_ipv4 = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        repeat (2) @(negedge clk);
        while (o_lpm_req && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        assert_eq("lookup_bound", 64'(o_lpm_req), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_hdr(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_hdr_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int rt;
        resetn = 1'b0;
        i_tvalid = 1'b0; i_tready = 1'b0; i_tlast = 1'b0; i_is_ipv4 = 1'b0;
        i_can_handle = 1'b0; i_csum_ok = 1'b0; i_ttl_ok = 1'b0; i_dst_ipv4 = '0;
        i_dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        assert_eq("rst_dec_valid", 64'(o_dec_valid), 64'd0);
        assert_eq("rst_lpm_req",   64'(o_lpm_req), 64'd0);
        assert_eq("rst_lpm_addr",  64'(o_lpm_addr), 64'd0);
        assert_eq("rst_hdr_ready", 64'(o_hdr_ready), 64'd1);
        assert_eq("rst_cnt_tmo",   64'(o_cnt_timeout), 64'd0);
        assert_eq("rst_dec_rec",   64'({o_dec_action, o_dec_port, o_dec_nexthop}), 64'd0);

        // 3-beat IPv4, hit after 2 cycles
        lpm_delay = 2; lpm_hit = 1'b1; lpm_port = 8'h04; lpm_nh = 32'h0A000101;
        send_pkt(3, 1, 1, 1, 1, 32'h0A000105, 1);
        wait_idle();
        assert_eq("lpm_addr", 64'(addr_seen), 64'h0A000105);
        assert_eq("lpm_req_len", 64'(req_len), 64'd3);

        // checksum failure: DROP, no lookup, 3-cycle latency after word2
        rt = req_total;
        send_pkt(3, 1, 1, 0, 1, 32'h0A000105, 1);
        wait_idle();
        assert_eq("drop_no_req", 64'(req_total), 64'(rt));
        assert_eq("drop_latency", 64'(valid_rise_cyc - word2_cyc), 64'd3);

        // ARP with bad verdicts still yields CPU
        send_pkt(2, 0, 0, 0, 1, 32'h0, 1);
        wait_idle();
        // one-beat IPv4 packet
        send_pkt(1, 1, 1, 1, 1, 32'h0A000105, 1);
        wait_idle();
        // can_handle / ttl failures
        send_pkt(3, 1, 0, 0, 1, 32'h0A000105, 1);
        wait_idle();
        send_pkt(2, 1, 1, 1, 0, 32'h0A000105, 1);
        wait_idle();

        // zero-cycle ack, directly connected (nexthop 0)
        lpm_delay = 0; lpm_hit = 1'b1; lpm_port = 8'h80; lpm_nh = 32'h0;
        send_pkt(2, 1, 1, 1, 1, 32'hC0A80102, 1);
        wait_idle();
        assert_eq("ack0_latency", 64'(valid_rise_cyc - word2_cyc), 64'd4);

        // timeout
        lpm_delay = 1000;
        send_pkt(3, 1, 1, 1, 1, 32'h0A000105, 1);
        wait_idle();
        assert_eq("tmo_req_len", 64'(req_len), 64'(LPM_TIMEOUT));
        assert_eq("tmo_count", 64'(o_cnt_timeout), 64'd1);

        // ack on the expiry cycle counts as an ack
        lpm_delay = LPM_TIMEOUT - 1; lpm_hit = 1'b1; lpm_port = 8'h10; lpm_nh = 32'h0B000001;
        send_pkt(3, 1, 1, 1, 1, 32'h0B000009, 1);
        wait_idle();
        assert_eq("late_ack_len", 64'(req_len), 64'(LPM_TIMEOUT));
        assert_eq("late_ack_tmo", 64'(o_cnt_timeout), 64'd1);

        // lookup miss
        lpm_delay = 1; lpm_hit = 1'b0;
        send_pkt(3, 1, 1, 1, 1, 32'h0C000001, 1);
        wait_idle();

        // stray ack while idle is ignored
        stray_req++;
        repeat (4) @(negedge clk);
        assert_eq("stray_valid", 64'(o_dec_valid), 64'd0);
        assert_eq("stray_tmo", 64'(o_cnt_timeout), 64'd1);

        // fill the decision FIFO with ready low
        @(posedge clk); #1 i_dec_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            wait_hdr(ok);
            assert_eq("fill_ready", 64'(ok), 64'd1);
            case (p)
                0: begin lpm_delay = 1; lpm_hit = 1; lpm_port = 8'h02; lpm_nh = 32'h0A000201;
                         send_pkt(3, 1, 1, 1, 1, 32'h0A000207, 1); end
                1:       send_pkt(2, 1, 1, 0, 1, 32'h0A000207, 1);
                2: begin lpm_delay = 0; lpm_hit = 1; lpm_port = 8'h20; lpm_nh = 32'h0A000301;
                         send_pkt(3, 1, 1, 1, 1, 32'h0A000305, 1); end
                default: send_pkt(2, 0, 1, 1, 1, 32'h0, 1);
            endcase
            wait_idle();
        end
        wait_hdr(ok);
        assert_eq("full_stall", 64'(ok), 64'd0);
        assert_eq("full_hdr_ready", 64'(o_hdr_ready), 64'd0);
        assert_eq("full_queued", 64'(exp_q.size()), 64'd4);
        assert_eq("full_valid", 64'(o_dec_valid), 64'd1);
        @(posedge clk); #1 i_dec_ready = 1'b1;
        repeat (8) @(negedge clk);
        assert_eq("drain_empty", 64'(exp_q.size()), 64'd0);
        assert_eq("drain_hdr_ready", 64'(o_hdr_ready), 64'd1);
        assert_eq("drain_valid", 64'(o_dec_valid), 64'd0);

        // reset in the middle of a lookup with two queued decisions
        @(posedge clk); #1 i_dec_ready = 1'b0;
        send_pkt(2, 0, 1, 1, 1, 32'h0, 1);
        wait_idle();
        send_pkt(1, 1, 1, 1, 1, 32'h0, 1);
        wait_idle();
        lpm_delay = 1000;
        send_pkt(3, 1, 1, 1, 1, 32'h0A0000FF, 0);
        repeat (3) @(negedge clk);
        assert_eq("pre_rst_req", 64'(o_lpm_req), 64'd1);
        assert_eq("pre_rst_valid", 64'(o_dec_valid), 64'd1);
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        assert_eq("rst_mid_valid", 64'(o_dec_valid), 64'd0);
        assert_eq("rst_mid_req", 64'(o_lpm_req), 64'd0);
        assert_eq("rst_mid_hdr", 64'(o_hdr_ready), 64'd1);
        assert_eq("rst_mid_tmo", 64'(o_cnt_timeout), 64'd0);
        @(posedge clk); #1 i_dec_ready = 1'b1;
        lpm_delay = 1; lpm_hit = 1'b1; lpm_port = 8'h01; lpm_nh = 32'hC0A80001;
        send_pkt(3, 1, 1, 1, 1, 32'hC0A80033, 1);
        wait_idle();
        assert_eq("post_rst_addr", 64'(addr_seen), 64'hC0A80033);
        repeat (4) @(negedge clk);

        assert_eq("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ipv4_fwd_sched.md
Name: ipv4_fwd_sched

Overview:
- Per-packet sequencer for the IPv4 check stage of the router output-port lookup.
- Snoops the input AXI-stream handshake and generates the word1/word2 strobes that drive the ipv4 checker.
- Samples the checker verdicts, then issues one request to the shared LPM lookup engine. Waits for the answer or a timeout.
- Queues one forwarding decision per packet in a small decision FIFO for the output-queue selector.

Parameters:
- DEC_DEPTH, 4: decision FIFO entries; power of 2, minimum 2.
- LPM_TIMEOUT, 64: cycles to wait for i_lpm_ack before giving up; range 1..255.
- NUM_PORTS, 8: width of the one-hot output port mask.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- i_tvalid  in  1  input stream tvalid (snooped).
- i_tready  in  1  input stream tready (snooped).
- i_tlast  in  1  input stream tlast (snooped).
- i_is_ipv4  in  1  ethertype 0x0800, valid on beat 1.
- o_pkt_word1  out  1  beat 1 of packet is transferring.
- o_pkt_word2  out  1  beat 2 of packet is transferring.
- o_hdr_ready  out  1  0 = stall new packet starts (decision FIFO full).
- i_can_handle  in  1  checker verdict, sampled in RES.
- i_csum_ok  in  1  checker verdict, sampled in RES.
- i_ttl_ok  in  1  checker verdict, sampled in RES.
- i_dst_ipv4  in  32  checker verdict, sampled in RES.
- o_lpm_req  out  1  lookup request, level, held until ack.
- o_lpm_addr  out  32  lookup key.
- i_lpm_ack  in  1  one-cycle lookup response strobe.
- i_lpm_hit  in  1  lookup matched.
- i_lpm_nexthop  in  32  next-hop IP.
- i_lpm_port  in  NUM_PORTS  one-hot output port.
- o_dec_valid  out  1  decision FIFO not empty.
- i_dec_ready  in  1  downstream pop.
- o_dec_action  out  2  0 FWD, 1 CPU, 2 DROP.
- o_dec_port  out  NUM_PORTS  output port mask.
- o_dec_nexthop  out  32  next-hop IP.
- o_cnt_timeout  out  16  saturating count of lookup timeouts.

Behaviour:
- A beat transfers when i_tvalid & i_tready.
- Beat counter: 0 after reset; increments per beat, saturating at 2; clears to 0 on a beat with i_tlast.
- o_pkt_word1 = beat & (cnt==0); o_pkt_word2 = beat & (cnt==1). Both are combinational.
- A one-beat packet (tlast on beat 1) produces no word2 and yields a CPU decision.
- o_hdr_ready = 0 when FIFO occupancy + in-flight decision ≥ DEC_DEPTH; otherwise 1.
- FSM states:
  - IDLE: on word1, latch i_is_ipv4.
    - If i_is_ipv4 = 0, go to PUSH with CPU.
    - If tlast is on the same beat, go to PUSH with CPU.
    - Otherwise go to HDR.
  - HDR: on word2 go to RES. On tlast without word2, go to PUSH with CPU.
  - RES: exactly 1 cycle after word2. Sample the four verdicts, then apply in priority order:
    - !can_handle → CPU.
    - !csum_ok → DROP.
    - !ttl_ok → CPU.
    - Otherwise latch dst, go to LOOKUP.
  - LOOKUP: o_lpm_req = 1, o_lpm_addr = latched dst; timer = 0.
    - On i_lpm_ack, sample the response, go to PUSH:
      - hit → FWD, port, nexthop (nexthop 0 means directly connected; pass through unchanged).
      - miss → CPU.
    - Timer reaching LPM_TIMEOUT without ack → CPU, o_cnt_timeout +1 (saturates at 16'hFFFF), go to PUSH.
    - An ack arriving in the same cycle as timer expiry counts as an ack.
  - PUSH: write {action, port, nexthop} into the FIFO (entry is guaranteed free by the hdr_ready gating), go to IDLE.
    - port and nexthop are 0 for CPU and DROP.
    - A word1 arriving in the PUSH cycle is accepted; the FSM goes to HDR or PUSH as in IDLE.
- Late or stray ack: i_lpm_ack outside LOOKUP is ignored.
- Decision FIFO:
  - Standard show-ahead: o_dec_* valid while o_dec_valid = 1.
  - Pop on o_dec_valid & i_dec_ready.
  - Simultaneous push and pop when full or empty are both legal; occupancy is unchanged when full.
  - Pointers wrap modulo DEC_DEPTH.
- Reset (resetn = 0 at a clk edge), including mid-operation:
  - FSM returns to IDLE; beat counter 0; FIFO emptied.
  - o_lpm_req 0, o_lpm_addr 0, o_dec_valid 0, o_dec_* 0, o_cnt_timeout 0, o_hdr_ready 1.
  - A partially processed packet produces no decision.
- Latency: non-lookup decision visible on o_dec_valid 3 cycles after word2; a 0-cycle ack adds 1 cycle.

Decomposition:
- Shared package ipv4_fwd_pkg holds:
  - action codes ACT_FWD = 2'd0, ACT_CPU = 2'd1, ACT_DROP = 2'd2.
  - FSM state encodings S_IDLE, S_HDR, S_RES, S_LOOKUP, S_PUSH.
  - decision record width (2 + NUM_PORTS + 32).
- One sub-module: fwd_dec_fifo (parameterised width/depth, sync FIFO with full, empty and count outputs).

Test Plan:
- 3-beat IPv4 packet, verdicts all 1, dst 10.0.1.5, ack after 2 cycles with hit, port 8'h04, nexthop 10.0.1.1 → one decision FWD / 8'h04 / 0x0A000101; o_lpm_addr = 0x0A000105.
- csum_ok = 0 (all other verdicts 1) → DROP; o_lpm_req never asserts.
- Ethertype ARP (i_is_ipv4 = 0) 2-beat packet → CPU; no word2-dependent sampling.
- Lookup never acks with LPM_TIMEOUT = 64 → CPU decision 64 cycles after LOOKUP entry; o_cnt_timeout = 1.
- i_dec_ready held 0 with back-to-back packets, DEC_DEPTH = 4 → exactly 4 decisions queued; o_hdr_ready = 0. Release ready → decisions pop in order; o_hdr_ready returns to 1.
- resetn = 0 during LOOKUP with 2 queued decisions → next cycle o_dec_valid = 0 and o_lpm_req = 0. A later packet processes normally.
